// File: rtl/arb_pkg.sv
// Shared types and sizing for the four-way round-robin arbiter.
package arb_pkg;
  typedef enum logic {IDLE, GRANT} state_t;
  localparam int N_REQ  = 4;
  localparam int HOLD_W = 8;
endpackage

// File: rtl/pri_enc4.sv
// Lowest-set-bit priority encoder; pos reads 0 when no input bit is set.
module pri_enc4 (
  input  logic [3:0] in,
  output logic [1:0] pos,
  output logic       valid
);
  always_comb begin
    pos   = 2'd0;
    valid = |in;
    if (in[0])      pos = 2'd0;
    else if (in[1]) pos = 2'd1;
    else if (in[2]) pos = 2'd2;
    else if (in[3]) pos = 2'd3;
  end
endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, one cycle grant latency,
// owner holds until it drops req (or MAX_HOLD expires); one idle cycle between grants.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       grant_id,
  output logic             busy
);
  localparam logic [HOLD_W-1:0] MaxHoldC = HOLD_W'(MAX_HOLD);

  state_t             state_q;
  logic [1:0]         ptr_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [N_REQ-1:0]   grant_q;
  logic [1:0]         id_q;

  logic [N_REQ-1:0]   rot_req;
  logic [1:0]         enc_pos;
  logic               enc_vld;
  logic [1:0]         win_d;
  logic [HOLD_W-1:0]  hold_d;
  logic               hold_expired;

  // Rotate right so that index ptr lands on bit 0 and is searched first.
  always_comb begin
    rot_req = req;
    case (ptr_q)
      2'd0: rot_req = req;
      2'd1: rot_req = {req[0],   req[3:1]};
      2'd2: rot_req = {req[1:0], req[3:2]};
      2'd3: rot_req = {req[2:0], req[3]};
      default: rot_req = req;
    endcase
  end

  pri_enc4 u_enc (
    .in    (rot_req),
    .pos   (enc_pos),
    .valid (enc_vld)
  );

  assign win_d        = enc_pos + ptr_q;
  assign hold_d       = (hold_q == {HOLD_W{1'b1}}) ? hold_q : hold_q + 1'b1;
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == MaxHoldC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      hold_q  <= '0;
      grant_q <= '0;
      id_q    <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_vld) begin
            grant_q <= N_REQ'(1) << win_d;
            id_q    <= win_d;
            ptr_q   <= win_d + 2'd1;
            hold_q  <= HOLD_W'(1);
            state_q <= GRANT;
          end else begin
            grant_q <= '0;
          end
        end
        GRANT: begin
          // Owner drop and limit expiry release identically, so one branch covers both.
          if (!req[id_q] || hold_expired) begin
            grant_q <= '0;
            hold_q  <= '0;
            state_q <= IDLE;
          end else begin
            hold_q  <= hold_d;
          end
        end
        default: begin
          grant_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = id_q;
  assign busy     = |grant_q;
endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: unlimited-hold instance (a) and MAX_HOLD=4 instance (b).
module tb_rr_arbiter4;
  logic       clk;
  logic       reset_a, reset_b;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] id_a, id_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] id;
  } exp_t;
  exp_t exp_q[$];

  rr_arbiter4 #(.MAX_HOLD(0)) dut0 (
    .clk(clk), .reset(reset_a), .req(req_a),
    .grant(grant_a), .grant_id(id_a), .busy(busy_a)
  );

  rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .reset(reset_b), .req(req_b),
    .grant(grant_b), .grant_id(id_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of req on instance d, queue the expected post-edge grant,
  // then pop and compare once the edge has passed.
  task automatic cyc(input int d, input logic [3:0] r, input logic [3:0] eg,
                     input logic [1:0] eid, input string nm);
    exp_t       e;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    if (d == 0) req_a = r; else req_b = r;
    exp_q.push_back('{g: eg, id: eid});
    @(posedge clk);
    @(negedge clk);
    e  = exp_q.pop_front();
    g  = (d == 0) ? grant_a : grant_b;
    id = (d == 0) ? id_a : id_b;
    b  = (d == 0) ? busy_a : busy_b;
    checks++;
    if (g !== e.g) $display("FAIL %s grant: got %b want %b", nm, g, e.g);
    else passed++;
    checks++;
    if (b !== (|e.g)) $display("FAIL %s busy: got %b want %b", nm, b, |e.g);
    else passed++;
    if (|e.g) begin
      checks++;
      if (id !== e.id) $display("FAIL %s grant_id: got %0d want %0d", nm, id, e.id);
      else passed++;
    end
  endtask

  task automatic pulse_reset_a();
    req_a   = 4'b0000;
    reset_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset_a = 1'b0;
  endtask

  task automatic check_ptr(input logic [1:0] want, input string nm);
    checks++;
    if (dut0.ptr_q !== want) $display("FAIL %s ptr: got %0d want %0d", nm, dut0.ptr_q, want);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (grant_a !== 4'b0000 || busy_a !== 1'b0 || id_a !== 2'd0)
      $display("FAIL reset outputs: got g=%b b=%b id=%0d want 0000/0/0", grant_a, busy_a, id_a);
    else passed++;
    check_ptr(2'd0, "reset");
    reset_a = 1'b0;
    reset_b = 1'b0;
  endtask

  task automatic test_first_grant();
    cyc(0, 4'b1111, 4'b0001, 2'd0, "first_grant");
    check_ptr(2'd1, "first_grant");
    cyc(0, 4'b0000, 4'b0000, 2'd0, "first_release");
  endtask

  task automatic test_hold_release();
    pulse_reset_a();
    for (int i = 0; i < 5; i++) cyc(0, 4'b0011, 4'b0001, 2'd0, "hold_owner0");
    cyc(0, 4'b0010, 4'b0000, 2'd0, "hold_gap");
    cyc(0, 4'b0010, 4'b0010, 2'd1, "hold_next1");
    cyc(0, 4'b0000, 4'b0000, 2'd0, "hold_end");
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    pulse_reset_a();
    for (int k = 0; k < 6; k++) begin
      oh = 4'b0001 << (k % 4);
      cyc(0, 4'b1111, oh, 2'(k % 4), "rr_grant");
      cyc(0, 4'b1111 & ~oh, 4'b0000, 2'd0, "rr_gap");
    end
    cyc(0, 4'b0000, 4'b0000, 2'd0, "rr_idle");
    check_ptr(2'd2, "rr_end");
  endtask

  task automatic test_idle_wrap();
    for (int i = 0; i < 10; i++) cyc(0, 4'b0000, 4'b0000, 2'd0, "idle_quiet");
    check_ptr(2'd2, "idle_hold_ptr");
    cyc(0, 4'b1000, 4'b1000, 2'd3, "wrap_grant3");
    check_ptr(2'd0, "wrap_ptr");
    cyc(0, 4'b0000, 4'b0000, 2'd0, "wrap_release");
  endtask

  task automatic test_async_reset();
    pulse_reset_a();
    cyc(0, 4'b0100, 4'b0100, 2'd2, "ar_grant2");
    req_a = 4'b1010;
    #1 reset_a = 1'b1;
    #1;
    checks++;
    if (grant_a !== 4'b0000 || busy_a !== 1'b0)
      $display("FAIL async_reset: got g=%b b=%b want 0000/0", grant_a, busy_a);
    else passed++;
    @(negedge clk);
    reset_a = 1'b0;
    cyc(0, 4'b1010, 4'b0010, 2'd1, "ar_after");
    cyc(0, 4'b0000, 4'b0000, 2'd0, "ar_release");
  endtask

  task automatic test_max_hold();
    for (int i = 0; i < 4; i++) cyc(1, 4'b0101, 4'b0001, 2'd0, "mh_owner0");
    cyc(1, 4'b0101, 4'b0000, 2'd0, "mh_gap0");
    for (int i = 0; i < 4; i++) cyc(1, 4'b0101, 4'b0100, 2'd2, "mh_owner2");
    cyc(1, 4'b0101, 4'b0000, 2'd0, "mh_gap2");
    cyc(1, 4'b0101, 4'b0001, 2'd0, "mh_back0");
    cyc(1, 4'b0000, 4'b0000, 2'd0, "mh_end");
  endtask

  initial begin
    reset_a = 1'b1;
    reset_b = 1'b1;
    req_a   = 4'b0000;
    req_b   = 4'b0000;
    test_reset();
    test_first_grant();
    test_hold_release();
    test_round_robin();
    test_idle_wrap();
    test_async_reset();
    test_max_hold();
    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-way round-robin arbiter that shares one downstream resource between four requesters. It uses a lowest-index priority encoder as its selection core and rotates the search start after every grant, so no requester can starve. Grants are registered and held for as long as the owner keeps requesting, with an optional hold limit. It sits between the requester blocks and the shared datapath, and drives that datapath's select lines.

## Interface
- `MAX_HOLD`, default 0: maximum cycles one grant may be held.
  - Range 0..255.
  - 0 disables the limit.
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input [3:0]: request lines. Bit i is requester i; level-sensitive.
- `grant` output [3:0]: one-hot grant, or all zero. Registered.
- `grant_id` output [1:0]: binary index of the current owner. Valid only when `busy`=1.
- `busy` output 1: high while any grant is asserted. Equals |grant.

## Operation
- State machine has two states: IDLE and GRANT.
- Rotation pointer `ptr[1:0]`: search starts at index ptr and proceeds ptr, ptr+1, ptr+2, ptr+3, all mod 4.
- Selection path:
  - Rotate `req` right by ptr.
  - Feed the result to a lowest-set-bit priority encoder, which gives `pos` and `valid`.
  - Winner = (pos + ptr) mod 4, using 2-bit wrap arithmetic.
- IDLE:
  - If `valid`, then at the edge: grant = onehot(winner), grant_id = winner, ptr = winner+1 (mod 4), hold count = 1, go to GRANT.
  - Otherwise stay in IDLE with outputs zero.
- GRANT:
  - If `req[grant_id]`=0, then at the edge: grant = 0, go to IDLE.
  - Else if MAX_HOLD≠0 and hold count == MAX_HOLD, then at the edge: grant = 0, go to IDLE (forced release).
  - Otherwise hold the grant and increment the hold count (8-bit, saturating).
- No re-arbitration while in GRANT. Requests from other requesters are ignored until the return to IDLE.
- ptr changes only when a grant is issued.
  - The owner just served is therefore always last in the next search.
  - This applies to both normal and forced release.
- Every IDLE cycle with req=0 leaves ptr unchanged.

## Timing
- Reset values: grant=0000, grant_id=00, busy=0, ptr=00, hold count=0, state=IDLE.
  - Outputs clear asynchronously on `reset` assertion, including in the middle of a grant.
- Grant latency: `req` sampled in IDLE at edge N gives grant visible after edge N (one cycle).
- Release latency: owner drops `req` before edge M; grant is 0 after edge M.
- Turnaround: at least one IDLE cycle between consecutive grants, even when other requests are pending.
  - Back-to-back requesters therefore see grant periods separated by one zero cycle.
- Forced release: the grant is high for exactly MAX_HOLD cycles.
- Simultaneous events:
  - Owner drop and MAX_HOLD expiry in the same cycle: treated as a normal release; the result is identical.
- Requester rules:
  - A requester may drop `req` at any time without waiting for a grant.
  - A request that disappears before it is sampled is simply lost; no latching.
- `grant` is never multi-hot and never changes owner without passing through 0.

## Structure
- Package `arb_pkg`:
  - State enum {IDLE, GRANT}.
  - Constant N_REQ = 4.
  - Constant HOLD_W = 8.
- Sub-module `pri_enc4`:
  - Combinational lowest-set-bit encoder.
  - Ports: in[3:0], pos[1:0], valid.
  - pos=0 when in=0.
  - Instantiated once in the selection path.
- Top `rr_arbiter4` holds the FSM, ptr, hold counter and output registers.

## Test plan
- Reset, then req=1111 → one cycle later grant=0001, grant_id=0, busy=1, ptr=1.
- req0 held 5 cycles then dropped, req1 high throughout → grant=0001 for 5 cycles, then 0000 for one cycle, then 0010, grant_id=1.
- All four requesters, each dropping `req` one cycle after being granted and re-raising it → grant order 0,1,2,3,0,1, with a zero cycle between each.
- MAX_HOLD=4, req0 and req2 stuck high → grant=0001 for exactly 4 cycles, one zero cycle, grant=0100 for 4 cycles, then 0001 again.
- Async `reset` pulsed mid-grant (grant=0100) → grant=0000 and busy=0 immediately, without waiting for an edge. After release with req=1010, the first grant is 0010 (ptr back to 0).
- req=0000 for 10 cycles → grant stays 0000, ptr unchanged. Then req=1000 alone → grant=1000, grant_id=3, and ptr wraps to 0.
